// File: rtl/display_pkg.sv
// Shared display geometry for the rotating panel: angular resolution, panel size
// and the slice-index type used by theta_slicer, the column fetch and hub75_output.
package display_pkg;

  localparam int unsigned ROTATIONAL_RES = 180;
  localparam int unsigned NUM_COLS       = ROTATIONAL_RES;
  localparam int unsigned NUM_ROWS       = 64;
  localparam int unsigned SCAN_RATE      = 32;
  localparam int unsigned THETA_RES      = $clog2(ROTATIONAL_RES);

  typedef logic [THETA_RES-1:0] theta_t;

endpackage

// File: rtl/hall_edge_detect.sv
// Brings the raw hall sensor into the clk_in domain and emits a registered
// one-cycle pulse on each rising edge.
module hall_edge_detect (
  input  logic clk_in,
  input  logic rst_in,
  input  logic hall_in,
  output logic edge_o
);

  logic sync1_q, sync2_q, prev_q, edge_q;

  // NOTE: non-blocking assignments so every flop samples the pre-edge value of its source.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      sync1_q <= hall_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      edge_q  <= sync2_q & ~prev_q;
    end
  end

  assign edge_o = edge_q;

endmodule

// File: rtl/theta_slicer.sv
// Angular timebase: measures the revolution period between accepted hall edges and
// spreads ROTATIONAL_RES slices evenly across it using a divider-free accumulator.
module theta_slicer #(
  parameter int unsigned ROTATIONAL_RES = display_pkg::ROTATIONAL_RES,
  parameter int unsigned PERIOD_WIDTH   = 24,
  parameter int unsigned DEBOUNCE       = 4096
) (
  input  logic                              clk_in,
  input  logic                              rst_in,
  input  logic                              hall_in,
  output logic [$clog2(ROTATIONAL_RES)-1:0] theta_out,
  output logic                              slice_pulse,
  output logic                              rev_pulse,
  output logic                              locked_out,
  output logic [PERIOD_WIDTH-1:0]           period_out
);

  localparam int unsigned TW = $clog2(ROTATIONAL_RES);
  localparam int unsigned AW = PERIOD_WIDTH + 1;

  localparam logic [PERIOD_WIDTH-1:0] CNT_MAX    = '1;
  localparam logic [PERIOD_WIDTH-1:0] DEB_MIN    = PERIOD_WIDTH'(DEBOUNCE - 1);
  localparam logic [AW-1:0]           RES_STEP   = AW'(ROTATIONAL_RES);
  localparam logic [TW-1:0]           THETA_LAST = TW'(ROTATIONAL_RES - 1);

  logic                    hall_edge;
  logic                    accept, saturated;
  logic [AW-1:0]           sum;

  logic [PERIOD_WIDTH-1:0] cnt_q, cnt_d;
  logic [PERIOD_WIDTH-1:0] period_q, period_d;
  logic [AW-1:0]           acc_q, acc_d;
  logic [TW-1:0]           theta_q, theta_d;
  logic                    locked_q, locked_d;
  logic                    armed_q, armed_d;
  logic                    slice_q, slice_d;
  logic                    rev_q, rev_d;

  hall_edge_detect u_hall_edge_detect (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .hall_in(hall_in),
    .edge_o (hall_edge)
  );

  // armed_q marks that cnt is timing from a real index edge, so the next accepted
  // edge yields a valid period; it is cleared by reset and by timeout.
  always_comb begin
    // NOTE: each _d starts from its _q so no branch leaves a value unassigned (no latch).
    cnt_d    = cnt_q;
    period_d = period_q;
    acc_d    = acc_q;
    theta_d  = theta_q;
    locked_d = locked_q;
    armed_d  = armed_q;
    slice_d  = 1'b0;
    rev_d    = 1'b0;

    saturated = (cnt_q == CNT_MAX);
    accept    = hall_edge && (cnt_q >= DEB_MIN);
    sum       = acc_q + RES_STEP;

    if (!saturated) cnt_d = cnt_q + 1'b1;

    if (accept) begin
      cnt_d   = '0;
      acc_d   = '0;
      theta_d = '0;
      rev_d   = 1'b1;
      armed_d = 1'b1;
      if (armed_q && !saturated) begin
        locked_d = 1'b1;
        period_d = cnt_q + 1'b1;
        slice_d  = 1'b1;
      end else begin
        locked_d = 1'b0;
      end
    end else if (saturated) begin
      locked_d = 1'b0;
      armed_d  = 1'b0;
      theta_d  = '0;
      acc_d    = '0;
    end else if (locked_q) begin
      if (sum >= {1'b0, period_q}) begin
        acc_d = sum - {1'b0, period_q};
        // Clamp at the last slice: a slowing rotor must not wrap into a second pass.
        if (theta_q < THETA_LAST) begin
          theta_d = theta_q + 1'b1;
          slice_d = 1'b1;
        end
      end else begin
        acc_d = sum;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cnt_q    <= '0;
      period_q <= '0;
      acc_q    <= '0;
      theta_q  <= '0;
      locked_q <= 1'b0;
      armed_q  <= 1'b0;
      slice_q  <= 1'b0;
      rev_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      period_q <= period_d;
      acc_q    <= acc_d;
      theta_q  <= theta_d;
      locked_q <= locked_d;
      armed_q  <= armed_d;
      slice_q  <= slice_d;
      rev_q    <= rev_d;
    end
  end

  assign theta_out   = theta_q;
  assign slice_pulse = slice_q;
  assign rev_pulse   = rev_q;
  assign locked_out  = locked_q;
  assign period_out  = period_q;

endmodule

// File: tb/tb_theta_slicer.sv
// Scoreboard bench for theta_slicer (R=4, DEBOUNCE=16, PERIOD_WIDTH=8): a cycle model
// predicts every strobe from the planned hall edges; a negedge monitor pops and compares.
module tb_theta_slicer;

  localparam int R  = 4;
  localparam int D  = 16;
  localparam int PW = 8;
  localparam int TW = $clog2(R);
  localparam int CMAX = (1 << PW) - 1;

  typedef struct {
    int cyc;
    bit rev;
    bit slc;
    int theta;
  } ev_t;

  typedef struct {
    int cyc;
    int theta;
    bit locked;
  } probe_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          hall = 1'b0;
  logic [TW-1:0] theta;
  logic          slice_pulse, rev_pulse, locked;
  logic [PW-1:0] period;

  int  cyc = 0;
  int  n_checks = 0;
  int  n_errors = 0;
  ev_t sb[$];
  ev_t mon_e;

  // Model state
  bit m_armed, m_locked;
  int m_period, m_origin, m_rev_v, m_next_n, m_last_rise;

  theta_slicer #(
    .ROTATIONAL_RES(R),
    .PERIOD_WIDTH  (PW),
    .DEBOUNCE      (D)
  ) dut (
    .clk_in     (clk),
    .rst_in     (rst),
    .hall_in    (hall),
    .theta_out  (theta),
    .slice_pulse(slice_pulse),
    .rev_pulse  (rev_pulse),
    .locked_out (locked),
    .period_out (period)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor: every pulse must match the oldest predicted event exactly.
  always @(negedge clk) begin
    if (slice_pulse || rev_pulse) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_pulse cyc=%0d rev=%0b slice=%0b theta=%0d, required no pulse",
                 cyc, rev_pulse, slice_pulse, theta);
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.cyc != cyc || rev_pulse !== mon_e.rev || slice_pulse !== mon_e.slc ||
            theta !== TW'(mon_e.theta)) begin
          n_errors++;
          $display("FAIL pulse_event got cyc=%0d rev=%0b slice=%0b theta=%0d, required cyc=%0d rev=%0b slice=%0b theta=%0d",
                   cyc, rev_pulse, slice_pulse, theta, mon_e.cyc, mon_e.rev, mon_e.slc, mon_e.theta);
        end
      end
    end
  end

  // Push slice events of the current revolution visible before 'bound'; apply timeout.
  function automatic void model_flush(input int bound);
    int t;
    if (m_locked) begin
      while (m_next_n < R) begin
        t = m_rev_v + (m_next_n * m_period + R - 1) / R;
        if (t >= bound || t >= m_origin + CMAX + 1) break;
        sb.push_back('{cyc: t, rev: 1'b0, slc: 1'b1, theta: m_next_n});
        m_next_n++;
      end
    end
    if (m_origin + CMAX + 1 <= bound) begin
      m_locked = 1'b0;
      m_armed  = 1'b0;
    end
  endfunction

  // A hall rise driven after posedge c shows up as rev_pulse sampled in cycle c+4.
  function automatic void model_plan(input int rises[$], input int end_cyc);
    int v, c;
    foreach (rises[i]) begin
      v = rises[i] + 4;
      c = v - 1 - m_origin;
      if (c > CMAX) c = CMAX;
      if (c >= D - 1) begin
        model_flush(v);
        m_locked = m_armed && (c != CMAX);
        if (m_locked) m_period = c + 1;
        m_armed  = 1'b1;
        m_origin = v;
        m_rev_v  = v;
        m_next_n = 1;
        sb.push_back('{cyc: v, rev: 1'b1, slc: m_locked, theta: 0});
      end
    end
    model_flush(end_cyc + 1);
  endfunction

  task automatic run_plan(input int rises[$], input probe_t probes[$], input int end_cyc);
    model_plan(rises, end_cyc);
    while (cyc < end_cyc) begin
      @(posedge clk);
      #1;
      hall = 1'b0;
      foreach (rises[i]) if (cyc >= rises[i] && cyc < rises[i] + 2) hall = 1'b1;
      @(negedge clk);
      foreach (probes[i]) begin
        if (probes[i].cyc == cyc) begin
          n_checks++;
          if (theta !== TW'(probes[i].theta) || locked !== probes[i].locked) begin
            n_errors++;
            $display("FAIL probe cyc=%0d got theta=%0d locked=%0b, required theta=%0d locked=%0b",
                     cyc, theta, locked, probes[i].theta, probes[i].locked);
          end
        end
      end
    end
    #1;
    n_checks++;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL missing_pulses at cyc=%0d got %0d events outstanding, required 0 (next due cyc=%0d)",
               cyc, sb.size(), sb[0].cyc);
    end
  endtask

  task automatic check_period(input string name, input int exp);
    n_checks++;
    if (period !== PW'(exp)) begin
      n_errors++;
      $display("FAIL %s period_out got %0d, required %0d", name, period, exp);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    n_checks++;
    if (theta !== '0 || slice_pulse !== 1'b0 || rev_pulse !== 1'b0 ||
        locked !== 1'b0 || period !== '0) begin
      n_errors++;
      $display("FAIL %s got theta=%0d slice=%0b rev=%0b locked=%0b period=%0d, required all 0",
               name, theta, slice_pulse, rev_pulse, locked, period);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_values");
    @(posedge clk);
    #2;
    rst = 1'b0;
    m_armed = 1'b0;
    m_locked = 1'b0;
    m_origin = cyc;
  endtask

  task automatic test_lock_and_slices();
    int r[$];
    probe_t p[$];
    int b, v2;
    b  = cyc + 30;
    v2 = b + 104;
    r  = '{b, b + 100, b + 200, b + 300};
    p.push_back('{v2 - 1, 0, 1'b0});
    p.push_back('{v2, 0, 1'b1});
    p.push_back('{v2 + 24, 0, 1'b1});
    p.push_back('{v2 + 25, 1, 1'b1});
    p.push_back('{v2 + 50, 2, 1'b1});
    p.push_back('{v2 + 75, 3, 1'b1});
    p.push_back('{v2 + 99, 3, 1'b1});
    run_plan(r, p, b + 394);
    check_period("lock", 100);
    m_last_rise = b + 300;
  endtask

  task automatic test_bounce();
    int r[$];
    probe_t p[$];
    int r0, v;
    r0 = m_last_rise + 100;
    v  = r0 + 104;
    r  = '{r0, r0 + 5, r0 + 100, r0 + 105, r0 + 200, r0 + 205};
    p.push_back('{v + 25, 1, 1'b1});
    p.push_back('{v + 50, 2, 1'b1});
    p.push_back('{v + 75, 3, 1'b1});
    run_plan(r, p, r0 + 284);
    check_period("bounce", 100);
    m_last_rise = r0 + 200;
  endtask

  task automatic test_slowdown();
    int r[$];
    probe_t p[$];
    int r0, v2, v3;
    r0 = m_last_rise + 100;
    v2 = r0 + 104;
    v3 = r0 + 244;
    r  = '{r0, r0 + 100, r0 + 240, r0 + 380};
    p.push_back('{v2 + 75, 3, 1'b1});
    p.push_back('{v2 + 99, 3, 1'b1});
    p.push_back('{v2 + 139, 3, 1'b1});
    p.push_back('{v3, 0, 1'b1});
    p.push_back('{v3 + 34, 0, 1'b1});
    p.push_back('{v3 + 35, 1, 1'b1});
    run_plan(r, p, r0 + 494);
    check_period("slowdown", 140);
    m_last_rise = r0 + 380;
  endtask

  task automatic test_coincident();
    int r[$];
    probe_t p[$];
    int a, v;
    a = m_last_rise + 140;
    v = a + 206;
    r = '{a, a + 101, a + 202, a + 303};
    p.push_back('{v - 1, 3, 1'b1});
    p.push_back('{v, 0, 1'b1});
    run_plan(r, p, a + 387);
    check_period("coincident", 101);
    m_last_rise = a + 303;
  endtask

  task automatic test_timeout();
    int r[$];
    probe_t p[$];
    int o, r1;
    o = m_last_rise + 4;
    p.push_back('{o + CMAX, 3, 1'b1});
    p.push_back('{o + CMAX + 1, 0, 1'b0});
    p.push_back('{o + CMAX + 10, 0, 1'b0});
    run_plan(r, p, o + CMAX + 15);
    r1 = cyc + 10;
    r  = '{r1, r1 + 100, r1 + 200};
    p  = {};
    p.push_back('{r1 + 4, 0, 1'b0});
    p.push_back('{r1 + 54, 0, 1'b0});
    p.push_back('{r1 + 104, 0, 1'b1});
    p.push_back('{r1 + 129, 1, 1'b1});
    run_plan(r, p, r1 + 284);
    check_period("relock", 100);
    m_last_rise = r1 + 200;
  endtask

  task automatic test_reset_mid();
    int r[$];
    probe_t p[$];
    int r0, v1;
    r0 = m_last_rise + 100;
    r  = '{r0};
    p.push_back('{r0 + 4 + 60, 2, 1'b1});
    run_plan(r, p, r0 + 64);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("reset_mid");
    m_armed  = 1'b0;
    m_locked = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    m_origin = cyc;
    r0 = cyc + 30;
    v1 = r0 + 4;
    r  = '{r0, r0 + 100, r0 + 200};
    p  = {};
    p.push_back('{v1, 0, 1'b0});
    p.push_back('{v1 + 50, 0, 1'b0});
    p.push_back('{v1 + 100, 0, 1'b1});
    p.push_back('{v1 + 150, 2, 1'b1});
    run_plan(r, p, r0 + 284);
    check_period("post_reset", 100);
  endtask

  initial begin
    test_reset();
    test_lock_and_slices();
    test_bounce();
    test_slowdown();
    test_coincident();
    test_timeout();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
